// File: rtl/tick_timer.sv
// Stopwatch timebase: divides clk by a runtime-loadable period, emits a one-cycle
// tick per period, supports pause/resume, clear, one-shot mode and counts ticks.
module tick_timer #(
    parameter int unsigned WIDTH          = 23,
    parameter int unsigned DEFAULT_PERIOD = 5000000,
    parameter int unsigned TICK_COUNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    mode,
    input  logic                    load_period,
    input  logic [WIDTH-1:0]        period_in,
    output logic [WIDTH-1:0]        count,
    output logic                    tick,
    output logic [TICK_COUNT_W-1:0] tick_count,
    output logic                    running,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [WIDTH-1:0]        count_reg, count_next;
    logic                    tick_reg, tick_next;
    logic [TICK_COUNT_W-1:0] tick_count_reg, tick_count_next;
    logic [WIDTH-1:0]        period_reg, period_next;
    logic [WIDTH-1:0]        period_eff;
    logic                    terminal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            tick_reg       <= 1'b0;
            tick_count_reg <= '0;
            period_reg     <= WIDTH'(DEFAULT_PERIOD);
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            tick_reg       <= tick_next;
            tick_count_reg <= tick_count_next;
            period_reg     <= period_next;
        end
    end

    // A zero period is treated as one; >= catches a count left above a shortened period.
    always_comb begin
        period_eff = (period_reg == '0) ? WIDTH'(1) : period_reg;
        terminal   = (count_reg >= (period_eff - WIDTH'(1)));
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        tick_next       = 1'b0;
        tick_count_next = tick_count_reg;
        period_next     = period_reg;

        if (clear) begin
            state_next      = IDLE;
            count_next      = '0;
            tick_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_next = '0;
                    if (start)
                        state_next = RUN;
                    if (load_period)
                        period_next = period_in;
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSED;
                    end else if (terminal) begin
                        count_next      = '0;
                        tick_next       = 1'b1;
                        tick_count_next = tick_count_reg + TICK_COUNT_W'(1);
                        if (mode)
                            state_next = DONE;
                    end else begin
                        count_next = count_reg + WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (start)
                        state_next = RUN;
                    if (load_period)
                        period_next = period_in;
                end
                DONE: begin
                    count_next = '0;
                    if (start)
                        state_next = RUN;
                    if (load_period)
                        period_next = period_in;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign count      = count_reg;
    assign tick       = tick_reg;
    assign tick_count = tick_count_reg;
    assign running    = (state_reg == RUN);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: table of per-cycle vectors plus hand-written corner
// sequences, with expected outputs queued at drive time and popped after the edge.
module tb_tick_timer;

    localparam int W  = 8;
    localparam int TW = 4;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b100000;
    localparam logic [5:0] C_ST   = 6'b010000;
    localparam logic [5:0] C_SP   = 6'b001000;
    localparam logic [5:0] C_CL   = 6'b000100;
    localparam logic [5:0] C_MD   = 6'b000010;
    localparam logic [5:0] C_LD   = 6'b000001;

    logic          clk = 1'b0;
    logic          reset, start, stop, clear, mode, load_period;
    logic [W-1:0]  period_in;
    logic [W-1:0]  count;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          running, done;

    typedef struct {
        logic [5:0]    ctl;
        logic [W-1:0]  pin;
        logic [W-1:0]  cnt;
        logic          tck;
        logic [TW-1:0] tc;
        logic          run;
        logic          dn;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    int checks = 0;
    int passed = 0;
    int step   = 0;

    tick_timer #(.WIDTH(W), .DEFAULT_PERIOD(5), .TICK_COUNT_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .load_period(load_period), .period_in(period_in),
        .count(count), .tick(tick), .tick_count(tick_count),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] ctl, input int pin, input int cnt,
                                input logic tck, input int tc, input logic run, input logic dn);
        vec_t v;
        v.ctl = ctl; v.pin = W'(pin); v.cnt = W'(cnt); v.tck = tck;
        v.tc = TW'(tc); v.run = run; v.dn = dn;
        return v;
    endfunction

    function automatic void add(input logic [5:0] ctl, input int pin, input int cnt,
                                input logic tck, input int tc, input logic run, input logic dn);
        tbl.push_back(mk(ctl, pin, cnt, tck, tc, run, dn));
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        reset       = v.ctl[5];
        start       = v.ctl[4];
        stop        = v.ctl[3];
        clear       = v.ctl[2];
        mode        = v.ctl[1];
        load_period = v.ctl[0];
        period_in   = v.pin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        step++;
        if ({count, tick, tick_count, running, done} !== {e.cnt, e.tck, e.tc, e.run, e.dn})
            $display("FAIL step%0d: got count=%0d tick=%0b tick_count=%0d running=%0b done=%0b, want count=%0d tick=%0b tick_count=%0d running=%0b done=%0b",
                     step, count, tick, tick_count, running, done, e.cnt, e.tck, e.tc, e.run, e.dn);
        else
            passed++;
        $display("step%0d ctl=%06b pin=%0d -> count=%0d tick=%0b tc=%0d run=%0b done=%0b",
                 step, v.ctl, v.pin, count, tick, tick_count, running, done);
    endtask

    task automatic drive(input logic [5:0] ctl, input int pin, input int cnt,
                         input logic tck, input int tc, input logic run, input logic dn);
        apply(mk(ctl, pin, cnt, tck, tc, run, dn));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        mode = 1'b0; load_period = 1'b0; period_in = '0;

        // Default period 5, periodic: ticks 5, 10, 15 edges after start
        add(C_RST, 0, 0, 0, 0, 0, 0);
        add(C_RST, 0, 0, 0, 0, 0, 0);
        add(C_NONE, 0, 0, 0, 0, 0, 0);
        add(C_SP, 0, 0, 0, 0, 0, 0);
        add(C_ST, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            for (int c = 1; c <= 4; c++) add(C_NONE, 0, c, 0, k-1, 1, 0);
            add(C_NONE, 0, 0, 1, k, 1, 0);
        end
        add(C_CL, 0, 0, 0, 0, 0, 0);

        // One-shot with period 3, then restart from DONE in periodic mode
        add(C_LD, 3, 0, 0, 0, 0, 0);
        add(C_ST | C_MD, 0, 0, 0, 0, 1, 0);
        add(C_MD, 0, 1, 0, 0, 1, 0);
        add(C_MD, 0, 2, 0, 0, 1, 0);
        add(C_MD, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(C_NONE, 0, 0, 0, 1, 0, 1);
        add(C_ST, 0, 0, 0, 1, 1, 0);
        add(C_NONE, 0, 1, 0, 1, 1, 0);
        add(C_NONE, 0, 2, 0, 1, 1, 0);
        add(C_NONE, 0, 0, 1, 2, 1, 0);
        add(C_CL, 0, 0, 0, 0, 0, 0);

        // Period 6, pause at 4, shorten to 2 while paused, start+stop priority
        add(C_LD, 6, 0, 0, 0, 0, 0);
        add(C_ST, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) add(C_NONE, 0, c, 0, 0, 1, 0);
        add(C_SP, 0, 4, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(C_NONE, 0, 4, 0, 0, 0, 0);
        add(C_LD, 2, 4, 0, 0, 0, 0);
        add(C_ST, 0, 4, 0, 0, 1, 0);
        add(C_NONE, 0, 0, 1, 1, 1, 0);
        add(C_NONE, 0, 1, 0, 1, 1, 0);
        add(C_ST | C_SP, 0, 1, 0, 1, 0, 0);
        add(C_ST | C_SP, 0, 1, 0, 1, 1, 0);
        add(C_NONE, 0, 0, 1, 2, 1, 0);
        add(C_CL, 0, 0, 0, 0, 0, 0);

        // Period 4: clear at count 3 / tick_count 7, period kept, load ignored under clear
        add(C_LD, 4, 0, 0, 0, 0, 0);
        add(C_ST, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            for (int c = 1; c <= 3; c++) add(C_NONE, 0, c, 0, k-1, 1, 0);
            add(C_NONE, 0, 0, 1, k, 1, 0);
        end
        for (int c = 1; c <= 3; c++) add(C_NONE, 0, c, 0, 7, 1, 0);
        add(C_CL, 0, 0, 0, 0, 0, 0);
        add(C_CL | C_LD, 7, 0, 0, 0, 0, 0);
        add(C_ST, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) add(C_NONE, 0, c, 0, 0, 1, 0);
        add(C_NONE, 0, 0, 1, 1, 1, 0);
        add(C_CL, 0, 0, 0, 0, 0, 0);
        add(C_ST | C_SP, 0, 0, 0, 0, 1, 0);
        add(C_NONE, 0, 1, 0, 0, 1, 0);
        add(C_CL, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Period 0 acts as 1: tick every cycle, tick_count wraps, load in RUN ignored
        drive(C_LD, 0, 0, 0, 0, 0, 0);
        drive(C_ST, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 17; k++) begin
            if (k == 5) drive(C_LD, 9, 0, 1, k % 16, 1, 0);
            else        drive(C_NONE, 0, 0, 1, k % 16, 1, 0);
        end
        drive(C_SP, 0, 0, 0, 1, 0, 0);
        drive(C_CL, 0, 0, 0, 0, 0, 0);

        // Reset mid-run aborts and restores the default period
        drive(C_LD, 2, 0, 0, 0, 0, 0);
        drive(C_ST, 0, 0, 0, 0, 1, 0);
        drive(C_NONE, 0, 1, 0, 0, 1, 0);
        drive(C_RST, 0, 0, 0, 0, 0, 0);
        drive(C_ST, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) drive(C_NONE, 0, c, 0, 0, 1, 0);
        drive(C_NONE, 0, 0, 1, 1, 1, 0);

        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
Parametrised stopwatch timebase. Divides clk by a runtime-loadable period and emits a one-cycle tick at each period boundary. Supports start/stop (pause), clear, and periodic or one-shot mode, and counts elapsed ticks. It sits between the system clock and the stopwatch digit counters and display logic.

Parameters:
WIDTH, 23, width of the prescale counter and period register
DEFAULT_PERIOD, 5000000, period loaded at reset (10 ms at 500 MHz-equivalent divide); must be < 2^WIDTH
TICK_COUNT_W, 16, width of the elapsed-tick counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level-sampled; starts or resumes counting
stop  in  1  level-sampled; pauses counting (effective only while running)
clear  in  1  synchronous clear of counts and state; period register kept
mode  in  1  0 = periodic, 1 = one-shot; sampled at the terminal edge
load_period  in  1  writes period_in into the period register
period_in  in  WIDTH  new period in clk cycles
count  out  WIDTH  current prescale count
tick  out  1  one-cycle pulse at each period boundary
tick_count  out  TICK_COUNT_W  elapsed ticks, wraps modulo 2^TICK_COUNT_W
running  out  1  high in RUN
done  out  1  high in DONE (one-shot complete)

Behaviour:
- Priority per edge: reset > clear > state logic.
- reset: state IDLE; count=0; tick=0; tick_count=0; running=0; done=0; period_reg=DEFAULT_PERIOD.
- clear: state IDLE; count=0; tick=0; tick_count=0; period_reg unchanged; load_period in the same cycle is ignored.
- States: IDLE, RUN, PAUSED, DONE. running=(RUN). done=(DONE). Both are registered state decodes.
- IDLE: count held at 0. start -> RUN.
- RUN: see the count and tick rules below. stop -> PAUSED, and count is held at its current value with no increment on that edge. If start and stop are both high in RUN, stop wins.
- PAUSED: count held. start -> RUN, resuming from the held count.
- DONE: count=0. start -> RUN, restarting from 0.
- stop in IDLE, PAUSED or DONE has no effect. If start and stop are both high there, start wins.
- Effective period: P = max(period_reg, 1). A period of 0 behaves as 1.
- Count in RUN with no stop:
  - If count >= P-1 (terminal edge): count<=0; tick<=1; tick_count<=tick_count+1 (wrapping). If mode=1, next state is DONE; otherwise the state stays RUN.
  - Otherwise: count<=count+1; tick<=0.
- The >= comparison covers a period shortened while PAUSED to below the held count: the next RUN edge is terminal.
- tick is 0 on every edge that is not a terminal edge, including pause and clear edges. tick is never high for two consecutive cycles unless P=1.
- Latency: start is sampled at edge E0 (state becomes RUN, count=0). tick is high in the cycle after edge E0+P. With P=1, tick is high every cycle while in RUN.
- load_period is accepted only in IDLE, PAUSED or DONE (period_reg<=period_in) and is ignored in RUN. It is independent of start in the same cycle: the new period applies from the following edge.
- Reset or clear asserted mid-run aborts immediately. No tick is emitted on that edge.
- Arithmetic: the count compare is unsigned WIDTH-bit. tick_count uses modular add.

Test Plan:
- Reset with DEFAULT_PERIOD=5 -> all outputs 0. Pulse start -> tick high in cycles 5, 10, 15 after start; count sequence 1,2,3,4,0; tick_count increments 1,2,3.
- Load period 3 in IDLE, mode=1, start -> one tick 3 cycles later; done=1 and running=0 the next cycle; count stays 0; further edges produce no tick. start again -> restarts.
- Period 6: stop at count=4 -> count holds 4 for 10 cycles with tick=0. Load period 2 while paused, then start -> terminal on the first RUN edge: count=0 and tick=1.
- Load period_in=0 -> tick high every cycle in RUN. load_period during RUN with value 9 -> ignored; spacing unchanged.
- clear at count=3 with tick_count=7 -> next cycle state IDLE, count=0, tick_count=0, tick=0. Period retained; verify on restart.
- TICK_COUNT_W=4, period 1: run 17 cycles -> tick_count wraps 15->0 and reads 1 after 17 ticks. start+stop together in RUN -> PAUSED; start+stop together in PAUSED -> RUN.
